// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes and multi-cycle unit handshake.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_de,
  input  logic [4:0]  rs2_de,
  input  logic        rs1_used_de,
  input  logic        rs2_used_de,
  input  logic [4:0]  rd_ex,
  input  logic        DMRd_ex,
  input  logic        br_taken_ex,
  input  logic        mc_req_de,
  input  logic        mc_done,
  output logic        mc_go,
  output logic        en_pc,
  output logic        en_fd,
  output logic        clr_fd,
  output logic        clr_de,
  output logic [1:0]  state,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MC_WAIT  = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t cur_state;
  state_t nxt_state;
  logic   load_use;
  logic   br_acc;

  assign load_use = DMRd_ex && (rd_ex != 5'd0) &&
                    ((rs1_used_de && (rs1_de == rd_ex)) ||
                     (rs2_used_de && (rs2_de == rd_ex)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= RUN;
    else        cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    mc_go     = 1'b0;
    en_pc     = 1'b1;
    en_fd     = 1'b1;
    clr_fd    = 1'b0;
    clr_de    = 1'b0;
    br_acc    = 1'b0;
    case (cur_state)
      MC_WAIT: begin
        // EX holds only bubbles here, so a branch indication cannot be genuine.
        if (mc_done) begin
          nxt_state = RUN;
        end else begin
          en_pc  = 1'b0;
          en_fd  = 1'b0;
          clr_de = 1'b1;
        end
      end
      default: begin
        // RUN, LD_STALL and FLUSH all arbitrate the same way.
        nxt_state = RUN;
        if (br_taken_ex) begin
          clr_fd    = 1'b1;
          clr_de    = 1'b1;
          br_acc    = 1'b1;
          nxt_state = FLUSH;
        end else if (load_use) begin
          en_pc     = 1'b0;
          en_fd     = 1'b0;
          clr_de    = 1'b1;
          nxt_state = LD_STALL;
        end else if (mc_req_de) begin
          mc_go     = 1'b1;
          en_pc     = 1'b0;
          en_fd     = 1'b0;
          clr_de    = 1'b1;
          nxt_state = MC_WAIT;
        end
      end
    endcase
    if (!rst_n) begin
      nxt_state = RUN;
      mc_go     = 1'b0;
      en_pc     = 1'b0;
      en_fd     = 1'b0;
      clr_fd    = 1'b1;
      clr_de    = 1'b1;
      br_acc    = 1'b0;
    end
  end

  assign state = cur_state;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (!en_pc) stall_cnt <= stall_cnt + 32'd1;
      if (br_acc) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
  assign flush_count  = flush_cnt;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: doc/pipe_seq_ctrl.md
PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 rs1_de, rs2_de  in  5 each  source register fields of the instruction in DE.
REQ-004 rs1_used_de, rs2_used_de  in  1 each  the DE instruction actually reads rs1 / rs2.
REQ-005 rd_ex  in  5  destination register of the instruction in EX.
REQ-006 DMRd_ex  in  1  EX instruction is a data-memory load.
REQ-007 br_taken_ex  in  1  EX resolved a taken branch or jump.
REQ-008 mc_req_de  in  1  DE instruction needs the multi-cycle unit.
REQ-009 mc_done  in  1  single-cycle completion pulse from the multi-cycle unit.
REQ-010 mc_go  out  1  single-cycle start pulse to the multi-cycle unit.
REQ-011 en_pc, en_fd  out  1 each  PC and FE/DE register enables.
REQ-012 clr_fd, clr_de  out  1 each  synchronous clears of FE/DE and DE/EX (bubble insert).
REQ-013 state  out  2  FSM state: RUN=0, LD_STALL=1, MC_WAIT=2, FLUSH=3.
REQ-014 stall_cycles, flush_count  out  32 each  performance counters (see Configuration).

Function
REQ-015 Load-use hazard = DMRd_ex & (rd_ex != 0) & ((rs1_used_de & rs1_de == rd_ex) | (rs2_used_de & rs2_de == rd_ex)).
REQ-016 Per-cycle priority, decided in RUN: br_taken_ex first, then load-use, then mc_req_de.
REQ-017 RUN with no event: en_pc = en_fd = 1; clr_fd = clr_de = 0; mc_go = 0.
REQ-018 br_taken_ex in RUN: clr_fd = clr_de = 1 and en_pc = 1 in the same cycle; next state FLUSH; mc_go is suppressed even if mc_req_de = 1.
REQ-019 FLUSH lasts exactly one cycle with RUN outputs, then returns to RUN; a second br_taken_ex in FLUSH is handled as in REQ-018.
REQ-020 Load-use in RUN: en_pc = en_fd = 0 and clr_de = 1 for that cycle; next state LD_STALL.
REQ-021 LD_STALL re-evaluates REQ-016 as if in RUN, so back-to-back hazards are handled, and the counter keeps counting.
REQ-022 mc_req_de in RUN with no higher-priority event: mc_go = 1 for one cycle; en_pc = en_fd = 0; clr_de = 1; next state MC_WAIT.
REQ-023 MC_WAIT without mc_done: en_pc = en_fd = 0, clr_de = 1, mc_go = 0; the block stays in MC_WAIT indefinitely.
REQ-024 MC_WAIT with mc_done: en_pc = en_fd = 1, clr_de = 0 (the instruction advances into EX); next state RUN; no new mc_go.
REQ-025 mc_done outside MC_WAIT is ignored; br_taken_ex in MC_WAIT is ignored because EX holds only bubbles.
REQ-026 Outputs are combinational from state and inputs; the state register is the only sequential element apart from the counters.

Reset
REQ-027 While rst_n = 0: state = RUN; mc_go = en_pc = en_fd = 0; clr_fd = clr_de = 1; counters = 0.
REQ-028 Reset asserted in MC_WAIT abandons the wait; after release, any mc_done is ignored until a new mc_go is issued.
REQ-029 The first rising clk edge after rst_n deasserts behaves as RUN.

Configuration
REQ-030 With PIPE_PERF_CNT_EN defined:
- stall_cycles increments on every cycle with en_pc = 0 while rst_n = 1.
- flush_count increments on every cycle with br_taken_ex accepted per REQ-018.
- Both counters wrap from 0xFFFFFFFF to 0.
REQ-031 Without PIPE_PERF_CNT_EN: both ports exist, are tied to 0, and no counter flops are built.

Verification
REQ-032 RUN, DMRd_ex = 1, rd_ex = 5, rs1_de = 5, rs1_used_de = 1 -> one cycle of en_pc = 0, clr_de = 1; state LD_STALL then RUN; stall_cycles +1.
REQ-033 Same as REQ-032 but rd_ex = 0, or rs1_used_de = 0 -> no stall; en_pc = 1.
REQ-034 mc_req_de = 1, mc_done 4 cycles after mc_go -> mc_go high exactly 1 cycle; en_pc low for 4 cycles, high on the mc_done cycle; stall_cycles +4.
REQ-035 br_taken_ex = 1 with mc_req_de = 1 and load-use true in the same cycle -> clr_fd = clr_de = 1, mc_go = 0, state FLUSH; flush_count +1.
REQ-036 rst_n pulsed low in MC_WAIT, then mc_done -> state RUN, mc_done ignored, no mc_go.
REQ-037 With PIPE_PERF_CNT_EN, stall_cycles forced to 0xFFFFFFFF, then one stall cycle -> stall_cycles = 0.
